// File: rtl/pc_unit.sv
// pc_unit: program counter with IDLE/RUN/HALTED control and optional return stack
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   start             begin execution at address 0 (from IDLE or HALTED)
//   stall, halt       hold pc this cycle / stop in HALTED at the current address
//   branch_en, target taken branch to an absolute address
//   call_en, ret_en   call/return through the return stack
//   pc                registered current instruction address
//   running, done     RUN / HALTED state decodes
//   stack_err         sticky return-stack overflow/underflow flag
// Macro PC_CALL_STACK_EN compiles in the STACK_DEPTH x PC_W return stack;
// without it call_en/ret_en are ignored and stack_err is tied low.
module pc_unit #(
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            halt,
    input  logic            branch_en,
    input  logic [PC_W-1:0] target,
    input  logic            call_en,
    input  logic            ret_en,
    output logic [PC_W-1:0] pc,
    output logic            running,
    output logic            done,
    output logic            stack_err
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
    state_t state;
    logic [PC_W-1:0] pc_inc;
    assign pc_inc  = pc + 1'b1;
    assign running = state == RUN;
    assign done    = state == HALTED;
`ifdef PC_CALL_STACK_EN
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int AW   = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0] sp, sp_dec;
    logic            full, empty, err;
    assign sp_dec    = sp - 1'b1;
    assign full      = sp == SP_W'(STACK_DEPTH);
    assign empty     = sp == '0;
    assign stack_err = err;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
            sp    <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    pc    <= '0;
                end
                RUN: if (halt) begin
                    state <= HALTED;
                end else if (!stall) begin
                    if (ret_en) begin
                        // an empty pop behaves like a plain increment
                        pc  <= empty ? pc_inc : stack[sp_dec[AW-1:0]];
                        sp  <= empty ? sp : sp_dec;
                        err <= err | empty;
                    end else if (call_en) begin
                        // a full push is dropped but the jump still happens
                        if (!full) begin
                            stack[sp[AW-1:0]] <= pc_inc;
                            sp                <= sp + 1'b1;
                        end
                        pc  <= target;
                        err <= err | full;
                    end else begin
                        pc <= branch_en ? target : pc_inc;
                    end
                end
                HALTED: if (start) begin
                    state <= RUN;
                    pc    <= '0;
                    sp    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    localparam int unused_depth = STACK_DEPTH;
    logic unused_ctrl;
    assign unused_ctrl = call_en | ret_en;
    assign stack_err   = 1'b0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    pc    <= '0;
                end
                RUN: if (halt) begin
                    state <= HALTED;
                end else if (!stall) begin
                    pc <= branch_en ? target : pc_inc;
                end
                HALTED: if (start) begin
                    state <= RUN;
                    pc    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, stall, halt, branch_en, call_en, ret_en;
    logic [11:0] target;
    logic [11:0] pc;
    logic        running, done, stack_err;
    int          total = 0;
    int          passed = 0;

    pc_unit #(.PC_W(12), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .branch_en(branch_en), .target(target), .call_en(call_en), .ret_en(ret_en),
        .pc(pc), .running(running), .done(done), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; stall = 0; halt = 0; branch_en = 0; call_en = 0; ret_en = 0; target = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0; start = 1;
        tick();
        total++; if (pc !== 12'd0) $display("FAIL reset_pc got %0d exp 0", pc); else passed++;
        total++; if (running !== 1'b0) $display("FAIL reset_running got %b exp 0", running); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
        total++; if (stack_err !== 1'b0) $display("FAIL reset_err got %b exp 0", stack_err); else passed++;
        rst_n = 1; start = 0; branch_en = 1; target = 12'd5;
        tick();
        total++; if (pc !== 12'd0) $display("FAIL idle_hold_pc got %0d exp 0", pc); else passed++;
        total++; if (running !== 1'b0) $display("FAIL idle_running got %b exp 0", running); else passed++;
        clear_inputs();
    endtask

    task automatic test_start();
        start = 1;
        tick();
        start = 0;
        total++; if (pc !== 12'd0) $display("FAIL start_pc got %0d exp 0", pc); else passed++;
        total++; if (running !== 1'b1) $display("FAIL start_running got %b exp 1", running); else passed++;
        total++; if (done !== 1'b0) $display("FAIL start_done got %b exp 0", done); else passed++;
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++; if (pc !== 12'(i)) $display("FAIL incr_pc got %0d exp %0d", pc, i); else passed++;
        end
    endtask

    task automatic test_branch();
        tick(); tick();
        total++; if (pc !== 12'd7) $display("FAIL pre_branch_pc got %0d exp 7", pc); else passed++;
        branch_en = 1; target = 12'd352;
        tick();
        total++; if (pc !== 12'd352) $display("FAIL branch_pc got %0d exp 352", pc); else passed++;
        branch_en = 0;
        tick();
        total++; if (pc !== 12'd353) $display("FAIL post_branch_pc got %0d exp 353", pc); else passed++;
    endtask

    task automatic test_wrap();
        branch_en = 1; target = 12'd4095;
        tick();
        branch_en = 0;
        total++; if (pc !== 12'd4095) $display("FAIL wrap_top got %0d exp 4095", pc); else passed++;
        tick();
        total++; if (pc !== 12'd0) $display("FAIL wrap_zero got %0d exp 0", pc); else passed++;
    endtask

    task automatic test_stall();
        branch_en = 1; target = 12'd10;
        tick();
        total++; if (pc !== 12'd10) $display("FAIL stall_setup got %0d exp 10", pc); else passed++;
        stall = 1; target = 12'd99;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pc !== 12'd10) $display("FAIL stall_hold got %0d exp 10", pc); else passed++;
        end
        stall = 0; branch_en = 0;
        tick();
        total++; if (pc !== 12'd11) $display("FAIL stall_release got %0d exp 11", pc); else passed++;
        start = 1;
        tick();
        start = 0;
        total++; if (pc !== 12'd12) $display("FAIL run_start_ignored got %0d exp 12", pc); else passed++;
    endtask

    task automatic test_call_ignored();
        call_en = 1; target = 12'd500;
        tick();
        call_en = 0;
        total++; if (pc !== 12'd13) $display("FAIL call_ignored got %0d exp 13", pc); else passed++;
        ret_en = 1;
        tick();
        total++; if (pc !== 12'd14) $display("FAIL ret_ignored got %0d exp 14", pc); else passed++;
        branch_en = 1; target = 12'd40;
        tick();
        ret_en = 0; branch_en = 0;
        total++; if (pc !== 12'd40) $display("FAIL ret_branch got %0d exp 40", pc); else passed++;
        total++; if (stack_err !== 1'b0) $display("FAIL err_tied got %b exp 0", stack_err); else passed++;
    endtask

    task automatic test_halt();
        branch_en = 1; target = 12'd20;
        tick();
        total++; if (pc !== 12'd20) $display("FAIL halt_setup got %0d exp 20", pc); else passed++;
        halt = 1; target = 12'd625;
        tick();
        halt = 0;
        total++; if (pc !== 12'd20) $display("FAIL halt_pc got %0d exp 20", pc); else passed++;
        total++; if (done !== 1'b1) $display("FAIL halt_done got %b exp 1", done); else passed++;
        total++; if (running !== 1'b0) $display("FAIL halt_running got %b exp 0", running); else passed++;
        tick();
        branch_en = 0;
        total++; if (pc !== 12'd20) $display("FAIL halted_hold got %0d exp 20", pc); else passed++;
        start = 1;
        tick();
        start = 0;
        total++; if (pc !== 12'd0) $display("FAIL restart_pc got %0d exp 0", pc); else passed++;
        total++; if (running !== 1'b1) $display("FAIL restart_running got %b exp 1", running); else passed++;
        total++; if (done !== 1'b0) $display("FAIL restart_done got %b exp 0", done); else passed++;
        tick();
        total++; if (pc !== 12'd1) $display("FAIL restart_incr got %0d exp 1", pc); else passed++;
    endtask

    task automatic test_reset_mid_run();
        branch_en = 1; target = 12'd300;
        tick();
        branch_en = 0;
        total++; if (pc !== 12'd300) $display("FAIL mid_setup got %0d exp 300", pc); else passed++;
        rst_n = 0; start = 1;
        tick();
        total++; if (pc !== 12'd0) $display("FAIL mid_reset_pc got %0d exp 0", pc); else passed++;
        total++; if (running !== 1'b0) $display("FAIL mid_reset_running got %b exp 0", running); else passed++;
        rst_n = 1; start = 0;
        tick();
        tick();
        total++; if (pc !== 12'd0) $display("FAIL mid_idle_pc got %0d exp 0", pc); else passed++;
        total++; if (running !== 1'b0) $display("FAIL mid_idle_running got %b exp 0", running); else passed++;
    endtask

`ifdef PC_CALL_STACK_EN
    task automatic test_call_stack();
        logic [11:0] tgt [5] = '{12'd100, 12'd200, 12'd300, 12'd400, 12'd500};
        logic [11:0] rets [4] = '{12'd301, 12'd201, 12'd101, 12'd10};
        start = 1; tick(); start = 0;
        branch_en = 1; target = 12'd8; tick(); branch_en = 0;
        call_en = 1; target = 12'd205; tick(); call_en = 0;
        total++; if (pc !== 12'd205) $display("FAIL call_pc got %0d exp 205", pc); else passed++;
        ret_en = 1; tick(); ret_en = 0;
        total++; if (pc !== 12'd9) $display("FAIL ret_pc got %0d exp 9", pc); else passed++;
        for (int i = 0; i < 5; i++) begin
            call_en = 1; target = tgt[i]; tick();
            total++; if (pc !== tgt[i]) $display("FAIL nest_pc got %0d exp %0d", pc, tgt[i]); else passed++;
            total++; if (stack_err !== (i == 4)) $display("FAIL nest_err got %b exp %b", stack_err, i == 4); else passed++;
        end
        call_en = 0;
        for (int i = 0; i < 4; i++) begin
            ret_en = 1; tick();
            total++; if (pc !== rets[i]) $display("FAIL unwind_pc got %0d exp %0d", pc, rets[i]); else passed++;
        end
        tick();
        ret_en = 0;
        total++; if (pc !== 12'd11) $display("FAIL empty_ret_pc got %0d exp 11", pc); else passed++;
        total++; if (stack_err !== 1'b1) $display("FAIL empty_ret_err got %b exp 1", stack_err); else passed++;
        rst_n = 0; tick(); rst_n = 1;
        total++; if (stack_err !== 1'b0) $display("FAIL err_clear got %b exp 0", stack_err); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_branch();
        test_wrap();
        test_stall();
`ifndef PC_CALL_STACK_EN
        test_call_ignored();
`endif
        test_halt();
        test_reset_mid_run();
`ifdef PC_CALL_STACK_EN
        test_call_stack();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
